// File: rtl/tlu_data_merger_if.sv
// Signal bundle for the TLU/data merger: two FWFT source FIFOs in, one merged FWFT buffer out.
// The master modport is the merger's view; slave is the surrounding environment.
interface tlu_data_merger_if;
    logic        TLU_FIFO_READ;
    logic        TLU_FIFO_EMPTY;
    logic [31:0] TLU_FIFO_DATA;
    logic        TLU_FIFO_PREEMPT_REQ;
    logic        DATA_FIFO_READ;
    logic        DATA_FIFO_EMPTY;
    logic [31:0] DATA_FIFO_DATA;
    logic        FIFO_READ;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic [15:0] TLU_WORD_CNT;
    logic [15:0] DATA_WORD_CNT;

    modport master (
        output TLU_FIFO_READ, DATA_FIFO_READ, FIFO_EMPTY, FIFO_DATA, TLU_WORD_CNT, DATA_WORD_CNT,
        input  TLU_FIFO_EMPTY, TLU_FIFO_DATA, TLU_FIFO_PREEMPT_REQ, DATA_FIFO_EMPTY,
               DATA_FIFO_DATA, FIFO_READ
    );

    modport slave (
        input  TLU_FIFO_READ, DATA_FIFO_READ, FIFO_EMPTY, FIFO_DATA, TLU_WORD_CNT, DATA_WORD_CNT,
        output TLU_FIFO_EMPTY, TLU_FIFO_DATA, TLU_FIFO_PREEMPT_REQ, DATA_FIFO_EMPTY,
               DATA_FIFO_DATA, FIFO_READ
    );
endinterface

// File: rtl/tlu_data_merger.sv
// Arbitrates between the TLU FIFO and the data FIFO in bounded bursts, with TLU preemption,
// and merges the popped words into a small FWFT output buffer.
module tlu_data_merger #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_BURST = 16
) (
    input logic               BUS_CLK,
    input logic               BUS_RST,
    tlu_data_merger_if.master bus
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]  BurstLast = 8'(MAX_BURST - 1);
    localparam logic [AW:0] CntDepth  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StGrantTlu, StGrantData} state_e;

    state_e          state_q;
    logic            last_tlu_q;  // 1: last grant was TLU, 0: last grant was DATA
    logic [7:0]      burst_q;
    logic [15:0]     tlu_cnt_q;
    logic [15:0]     data_cnt_q;
    logic [AW:0]     count_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [31:0]     mem_q [DEPTH];

    logic            rd_en;
    logic            space;
    logic            tlu_pop;
    logic            data_pop;
    logic            wr_en;
    logic [31:0]     wr_data;
    logic            burst_done;

    always_comb begin
        rd_en      = bus.FIFO_READ & (count_q != '0);
        // A same-cycle downstream read frees the slot the incoming word needs.
        space      = (count_q < CntDepth) | rd_en;
        tlu_pop    = (state_q == StGrantTlu) & ~bus.TLU_FIFO_EMPTY & space;
        data_pop   = (state_q == StGrantData) & ~bus.DATA_FIFO_EMPTY & space;
        wr_en      = tlu_pop | data_pop;
        wr_data    = tlu_pop ? bus.TLU_FIFO_DATA : bus.DATA_FIFO_DATA;
        burst_done = burst_q >= BurstLast;
    end

    assign bus.TLU_FIFO_READ  = tlu_pop;
    assign bus.DATA_FIFO_READ = data_pop;
    assign bus.FIFO_EMPTY     = (count_q == '0);
    assign bus.FIFO_DATA      = mem_q[rd_ptr_q];
    assign bus.TLU_WORD_CNT   = tlu_cnt_q;
    assign bus.DATA_WORD_CNT  = data_cnt_q;

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q    <= StIdle;
            last_tlu_q <= 1'b0;
            burst_q    <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    burst_q <= 8'd0;
                    if (bus.TLU_FIFO_PREEMPT_REQ && !bus.TLU_FIFO_EMPTY) begin
                        state_q <= StGrantTlu;
                    end else if (!bus.TLU_FIFO_EMPTY && !bus.DATA_FIFO_EMPTY) begin
                        state_q <= last_tlu_q ? StGrantData : StGrantTlu;
                    end else if (!bus.TLU_FIFO_EMPTY) begin
                        state_q <= StGrantTlu;
                    end else if (!bus.DATA_FIFO_EMPTY) begin
                        state_q <= StGrantData;
                    end
                end
                StGrantTlu: begin
                    if (bus.TLU_FIFO_EMPTY) begin
                        state_q    <= StIdle;
                        last_tlu_q <= 1'b1;
                    end else if (tlu_pop) begin
                        if (burst_done && !bus.TLU_FIFO_PREEMPT_REQ) begin
                            state_q    <= StIdle;
                            last_tlu_q <= 1'b1;
                        end
                        // Saturate so a long preempted run cannot wrap past the limit.
                        if (burst_q != 8'hFF) burst_q <= burst_q + 8'd1;
                    end
                end
                StGrantData: begin
                    if (bus.TLU_FIFO_PREEMPT_REQ && !bus.TLU_FIFO_EMPTY) begin
                        state_q    <= StGrantTlu;
                        last_tlu_q <= 1'b0;
                        burst_q    <= 8'd0;
                    end else if (bus.DATA_FIFO_EMPTY) begin
                        state_q    <= StIdle;
                        last_tlu_q <= 1'b0;
                    end else if (data_pop) begin
                        if (burst_done) begin
                            state_q    <= StIdle;
                            last_tlu_q <= 1'b0;
                        end
                        if (burst_q != 8'hFF) burst_q <= burst_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            tlu_cnt_q  <= 16'd0;
            data_cnt_q <= 16'd0;
        end else begin
            if (tlu_pop && tlu_cnt_q != 16'hFFFF)   tlu_cnt_q  <= tlu_cnt_q + 16'd1;
            if (data_pop && data_cnt_q != 16'hFFFF) data_cnt_q <= data_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr_en && !rd_en)      count_q <= count_q + (AW + 1)'(1);
            else if (!wr_en && rd_en) count_q <= count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule
